// File: rtl/branch_unit.sv
// Branch decision stage: holds the ALU flags and a jump-target LUT, and turns
// the decoded branch op into the PC jump controls. HALT freezes the PC until reset.
module branch_unit #(
    parameter int D = 12,
    parameter int L = 4,
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flag_we,
    input  logic         z_in,
    input  logic         c_in,
    input  logic         n_in,
    input  logic [2:0]   br_op,
    input  logic [L-1:0] lut_idx,
    input  logic         lut_we,
    input  logic [L-1:0] lut_waddr,
    input  logic [D-1:0] lut_wdata,
    output logic         branch_en,
    output logic         reljump_en,
    output logic         absjump_en,
    output logic [D-1:0] target,
    output logic         done,
    output logic [C-1:0] taken_cnt
);
    localparam int N = 2 ** L;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_BZ   = 3'd1;
    localparam logic [2:0] OP_BNZ  = 3'd2;
    localparam logic [2:0] OP_BC   = 3'd3;
    localparam logic [2:0] OP_BN   = 3'd4;
    localparam logic [2:0] OP_JREL = 3'd5;
    localparam logic [2:0] OP_JABS = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic {ST_RUN, ST_DONE} state_t;

    state_t       state_reg;
    logic         done_reg;
    logic         z_reg, c_reg, n_reg;
    logic [C-1:0] cnt_reg;
    logic [D-1:0] lut_mem [N];
    logic [D-1:0] lut_rd;

    logic         branch_next;
    logic         rel_next;
    logic         abs_next;
    logic [D-1:0] target_next;
    logic         run_taken;

    // Flags are only ever read from the registers, so a same-cycle branch sees the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_reg <= 1'b0;
            c_reg <= 1'b0;
            n_reg <= 1'b0;
        end else if (flag_we) begin
            z_reg <= z_in;
            c_reg <= c_in;
            n_reg <= n_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                lut_mem[i] <= '0;
            end
        end else if (lut_we) begin
            lut_mem[lut_waddr] <= lut_wdata;
        end
    end

    assign lut_rd = lut_mem[lut_idx];

    always_comb begin
        branch_next = 1'b0;
        rel_next    = 1'b0;
        abs_next    = 1'b0;
        target_next = '0;
        if (state_reg == ST_DONE || br_op == OP_HALT) begin
            // Relative jump by zero keeps the PC parked on the HALT address.
            branch_next = 1'b1;
            rel_next    = 1'b1;
        end else begin
            case (br_op)
                OP_BZ, OP_BNZ, OP_BC, OP_BN: begin
                    if ((br_op == OP_BZ  &&  z_reg) ||
                        (br_op == OP_BNZ && !z_reg) ||
                        (br_op == OP_BC  &&  c_reg) ||
                        (br_op == OP_BN  &&  n_reg)) begin
                        branch_next = 1'b1;
                        rel_next    = 1'b1;
                        target_next = lut_rd;
                    end
                end
                OP_JREL: begin
                    branch_next = 1'b1;
                    rel_next    = 1'b1;
                    target_next = lut_rd;
                end
                OP_JABS: begin
                    branch_next = 1'b1;
                    abs_next    = 1'b1;
                    target_next = lut_rd;
                end
                default: ;
            endcase
        end
    end

    assign run_taken = (state_reg == ST_RUN) && (br_op != OP_HALT) && branch_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (br_op == OP_HALT) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= ST_RUN;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (run_taken && cnt_reg != {C{1'b1}}) begin
            cnt_reg <= cnt_reg + C'(1);
        end
    end

    // Decision outputs are combinational; hold them at zero while reset is asserted.
    assign branch_en  = branch_next & ~reset;
    assign reljump_en = rel_next & ~reset;
    assign absjump_en = abs_next & ~reset;
    assign target     = reset ? '0 : target_next;
    assign done       = done_reg;
    assign taken_cnt  = cnt_reg;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a vector table for the main decision path,
// plus hand sequences for async reset, LUT scan and counter saturation.
module tb_branch_unit;
    localparam int D = 12;
    localparam int L = 4;
    localparam int C = 4;

    logic         clk;
    logic         reset;
    logic         flag_we, z_in, c_in, n_in;
    logic [2:0]   br_op;
    logic [L-1:0] lut_idx;
    logic         lut_we;
    logic [L-1:0] lut_waddr;
    logic [D-1:0] lut_wdata;
    logic         branch_en, reljump_en, absjump_en, done;
    logic [D-1:0] target;
    logic [C-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    branch_unit #(.D(D), .L(L), .C(C)) dut (
        .clk(clk), .reset(reset),
        .flag_we(flag_we), .z_in(z_in), .c_in(c_in), .n_in(n_in),
        .br_op(br_op), .lut_idx(lut_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .branch_en(branch_en), .reljump_en(reljump_en), .absjump_en(absjump_en),
        .target(target), .done(done), .taken_cnt(taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [L-1:0] idx;
        logic         fwe;
        logic [2:0]   zcn;
        logic         lwe;
        logic [L-1:0] waddr;
        logic [D-1:0] wdata;
        logic         e_br, e_rel, e_abs;
        logic [D-1:0] e_tgt;
        logic         e_done;
        logic [C-1:0] e_cnt;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [L-1:0] idx,
                         input logic fwe, input logic [2:0] zcn,
                         input logic lwe, input logic [L-1:0] waddr, input logic [D-1:0] wdata);
        br_op     = op;
        lut_idx   = idx;
        flag_we   = fwe;
        z_in      = zcn[2];
        c_in      = zcn[1];
        n_in      = zcn[0];
        lut_we    = lwe;
        lut_waddr = waddr;
        lut_wdata = wdata;
    endtask

    task automatic check_out(input string tag, input logic e_br, input logic e_rel,
                             input logic e_abs, input logic [D-1:0] e_tgt,
                             input logic e_done, input logic [C-1:0] e_cnt);
        check({tag, " branch_en"},  32'(branch_en),  32'(e_br));
        check({tag, " reljump_en"}, 32'(reljump_en), 32'(e_rel));
        check({tag, " absjump_en"}, 32'(absjump_en), 32'(e_abs));
        check({tag, " target"},     32'(target),     32'(e_tgt));
        check({tag, " done"},       32'(done),       32'(e_done));
        check({tag, " taken_cnt"},  32'(taken_cnt),  32'(e_cnt));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            op    idx  fwe zcn     lwe wa   wdata    br rel abs tgt      dn cnt
        vecs[0]  = '{3'd0, 4'd3, 0, 3'b000, 1, 4'd3, 12'hFFE, 0, 0, 0, 12'h000, 0, 4'd0};
        vecs[1]  = '{3'd1, 4'd3, 1, 3'b100, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd0};
        vecs[2]  = '{3'd1, 4'd3, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'hFFE, 0, 4'd0};
        vecs[3]  = '{3'd2, 4'd3, 0, 3'b000, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd1};
        vecs[4]  = '{3'd3, 4'd3, 1, 3'b011, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd1};
        vecs[5]  = '{3'd3, 4'd3, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'hFFE, 0, 4'd1};
        vecs[6]  = '{3'd4, 4'd3, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'hFFE, 0, 4'd2};
        vecs[7]  = '{3'd2, 4'd3, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'hFFE, 0, 4'd3};
        vecs[8]  = '{3'd6, 4'd5, 0, 3'b000, 1, 4'd5, 12'h0A0, 1, 0, 1, 12'h000, 0, 4'd4};
        vecs[9]  = '{3'd6, 4'd5, 0, 3'b000, 0, 4'd0, 12'h000, 1, 0, 1, 12'h0A0, 0, 4'd5};
        vecs[10] = '{3'd5, 4'd5, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'h0A0, 0, 4'd6};
        vecs[11] = '{3'd0, 4'd5, 0, 3'b000, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd7};
        vecs[12] = '{3'd1, 4'd5, 0, 3'b000, 0, 4'd0, 12'h000, 0, 0, 0, 12'h000, 0, 4'd7};
        vecs[13] = '{3'd7, 4'd5, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'h000, 0, 4'd7};
        vecs[14] = '{3'd6, 4'd5, 0, 3'b000, 0, 4'd0, 12'h000, 1, 1, 0, 12'h000, 1, 4'd7};
        vecs[15] = '{3'd0, 4'd5, 0, 3'b000, 1, 4'd7, 12'h123, 1, 1, 0, 12'h000, 1, 4'd7};

        reset = 1'b1;
        drive(3'd6, 4'd0, 1'b0, 3'b000, 1'b0, 4'd0, 12'h000);
        #2;
        $display("reset held at start");
        check_out("init_reset", 0, 0, 0, 12'h000, 0, 4'd0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].op, vecs[i].idx, vecs[i].fwe, vecs[i].zcn,
                  vecs[i].lwe, vecs[i].waddr, vecs[i].wdata);
            #3;
            $display("vec %0d op=%0d idx=%0d br=%0b rel=%0b abs=%0b tgt=%h done=%0b cnt=%0d",
                     i, vecs[i].op, vecs[i].idx, branch_en, reljump_en, absjump_en,
                     target, done, taken_cnt);
            check_out($sformatf("vec%0d", i), vecs[i].e_br, vecs[i].e_rel, vecs[i].e_abs,
                      vecs[i].e_tgt, vecs[i].e_done, vecs[i].e_cnt);
            next_cycle();
        end

        // Asynchronous reset from DONE: outputs drop before any clock edge.
        drive(3'd0, 4'd0, 1'b0, 3'b000, 1'b0, 4'd0, 12'h000);
        reset = 1'b1;
        #2;
        $display("reset asserted mid-run br=%0b done=%0b cnt=%0d", branch_en, done, taken_cnt);
        check_out("midrun_reset", 0, 0, 0, 12'h000, 0, 4'd0);
        next_cycle();
        reset = 1'b0;

        // Every LUT entry (including 3, 5, 7 written earlier) must read zero.
        for (int k = 0; k < 16; k++) begin
            drive(3'd6, 4'(k), 1'b0, 3'b000, 1'b0, 4'd0, 12'h000);
            #3;
            $display("lut scan idx=%0d tgt=%h abs=%0b cnt=%0d", k, target, absjump_en, taken_cnt);
            check_out($sformatf("lut%0d", k), 1, 0, 1, 12'h000, 0, 4'(k));
            next_cycle();
        end

        // Saturation: 2**C+3 taken JRELs from a fresh reset.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive(3'd0, 4'd0, 1'b0, 3'b000, 1'b1, 4'd2, 12'h7FF);
        next_cycle();
        for (int i = 0; i < 19; i++) begin
            drive(3'd5, 4'd2, 1'b0, 3'b000, 1'b0, 4'd0, 12'h000);
            #3;
            $display("jrel %0d tgt=%h cnt=%0d", i, target, taken_cnt);
            check_out($sformatf("sat%0d", i), 1, 1, 0, 12'h7FF, 0, (i > 15) ? 4'd15 : 4'(i));
            next_cycle();
        end
        drive(3'd0, 4'd0, 1'b0, 3'b000, 1'b0, 4'd0, 12'h000);
        #3;
        $display("after saturation cnt=%0d", taken_cnt);
        check_out("sat_final", 0, 0, 0, 12'h000, 0, 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
